i2c_mslave: RTL and testbench
=============================

Name: i2c_mslave

Overview:
I2C target (slave) endpoint for the I2C master in the same design. It serves a local 8-bit-addressed byte store through an 8-bit register pointer. Supports byte-write, page-write, random-read, current-address-read and sequential-read transactions. It sits between the open-drain sda/scl pins and a local register file or memory, and never drives scl (no clock stretching).

Parameters:
SYNC_STAGES, 2, number of flip-flop stages synchronising sda and scl into clock_i (minimum 2)

Ports:
clock_i   input   1  system clock; must run at 10x the scl frequency or faster
reset_i   input   1  reset; asynchronous, active-high
enable_i  input   1  responds to its address only while high
devadr_i  input   7  own 7-bit device address
dat_i     input   8  read data from local store; must be valid the cycle after rd_o
dat_o     output  8  byte received from master (write data)
adr_o     output  8  current register pointer
wr_o      output  1  one-cycle pulse: write dat_o to adr_o
rd_o      output  1  one-cycle pulse: fetch byte at adr_o onto dat_i
busy_o    output  1  high from an address-matched ACK until STOP or return to idle
sda       inout   1  I2C data; driven low only, otherwise Z
scl       input   1  I2C clock; sampled only

Behaviour:
- Reset (async): state S_IDLE; sda released; dat_o=0, adr_o=0, wr_o=0, rd_o=0, busy_o=0.
- sda and scl pass through SYNC_STAGES flops plus one history flop. All decisions use the synchronised values.
- Edge and condition detection:
  - scl_rise / scl_fall: synchronised scl edges.
  - START: sda falls while scl=1. STOP: sda rises while scl=1.
  - START and STOP take priority over bit events in the same cycle.
- Data timing: input bits are sampled on scl_rise, MSB first. Outputs (ACK or data bits) change only on scl_fall.
- START or repeated START, from any state: go to S_ADDR, bit counter=8, sda released.
- STOP, from any state: go to S_IDLE, sda released, busy_o=0. A partial byte is discarded; no wr_o is issued.
- States:
  - S_IDLE: wait for START.
  - S_ADDR: shift 8 bits. On the 8th scl_fall:
    - If byte[7:1]==devadr_i and enable_i=1: drive sda=0, busy_o=1, go to S_ACK_ADDR.
    - Otherwise go to S_IDLE (ignore bus until the next START).
  - S_ACK_ADDR: hold ACK through the 9th clock; release on the next scl_fall.
    - R/W=0: go to S_REG.
    - R/W=1: pulse rd_o at the ACK scl_rise, capture dat_i into the tx shift register one cycle later, drive MSB at the ACK-ending scl_fall, go to S_RDATA.
  - S_REG: 8 bits, then ACK. The byte loads adr_o. Then go to S_WDATA.
  - S_WDATA: 8 bits. On the 8th scl_fall: dat_o=byte, wr_o pulses one cycle, ACK driven, go to S_ACK_WDATA.
  - S_ACK_WDATA: on the ACK-ending scl_fall, adr_o=adr_o+1, then back to S_WDATA.
  - S_RDATA: drive tx bits on scl_fall. sda is released (Z) for '1' and driven low for '0'. After 8 bits, release sda and go to S_CHK_ACK.
  - S_CHK_ACK: sample sda at the 9th scl_rise; adr_o=adr_o+1 in both cases.
    - ACK (0): pulse rd_o, reload from dat_i, drive MSB on the next scl_fall, go to S_RDATA.
    - NACK (1): go to S_WAIT_STOP.
  - S_WAIT_STOP: sda released; wait for STOP or repeated START.
- Pointer: adr_o wraps 8'hFF -> 8'h00. It persists across transactions (current-address-read returns the byte at the pointer left by the previous access). It is cleared only by reset.
- Repeated START after S_REG gives random-read; adr_o is kept.
- enable_i falling mid-transaction: the current transaction completes. Only subsequent address matches are refused (NACK).
- wr_o and rd_o never assert in the same cycle.

Decomposition:
- Shared package: state encodings S_IDLE..S_WAIT_STOP (4-bit), ACK=1'b0 and NACK=1'b1 constants, SYNC_STAGES default.
- Sub-module i2c_line_sync: synchroniser and edge detector. Outputs scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det.
- All remaining logic lives in i2c_mslave (target 200-300 lines total).

Test Plan:
- Byte-write: START, 0xA0 (devadr_i=7'h50), 0x10, 0x5A, STOP -> three ACKs; one wr_o with adr_o=0x10, dat_o=0x5A; adr_o=0x11 after; busy_o falls at STOP.
- Page-write wrap: reg 0xFE, data 0x01,0x02,0x03 -> wr_o at 0xFE,0xFF,0x00; adr_o=0x01 at end.
- Random-read: START 0xA0, 0x20, repeated START 0xA1, master ACK,ACK,NACK, STOP; local store returns 0x20+adr -> bytes 0x40,0x41,0x42 on sda; rd_o three times; adr_o=0x23.
- Current-address-read then NACK: START 0xA1 with adr_o=0x23 -> byte 0x43; enters S_WAIT_STOP; sda released; adr_o=0x24.
- Address mismatch: START 0xA2 and enable_i=0 with 0xA0 -> no ACK (sda stays Z through the 9th clock); no wr_o/rd_o; busy_o=0.
- Abort/reset: STOP after 4 data bits -> no wr_o, S_IDLE. reset_i asserted mid-read -> sda released within the same cycle, all outputs 0.

Source files
------------

// File: rtl/i2c_mslave_pkg.sv
// Shared definitions for the I2C target endpoint: FSM state encoding,
// acknowledge bit values and the default synchroniser depth.
`timescale 1ns/1ps
package i2c_mslave_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ACK_ADDR  = 4'd2,
    S_REG       = 4'd3,
    S_ACK_REG   = 4'd4,
    S_WDATA     = 4'd5,
    S_ACK_WDATA = 4'd6,
    S_RDATA     = 4'd7,
    S_CHK_ACK   = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  localparam logic ACK             = 1'b0;
  localparam logic NACK            = 1'b1;
  localparam int   SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the sda/scl pins into the local clock and derives clock
// edges plus START/STOP conditions from the synchronised history.
`timescale 1ns/1ps
module i2c_line_sync
  import i2c_mslave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;

  // Flops reset to the idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
      r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = r_scl_sync[SYNC_STAGES-1];
  assign sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~r_scl_hist;
  assign scl_fall  = ~scl_s & r_scl_hist;
  assign start_det = scl_s & r_scl_hist & r_sda_hist & ~sda_s;
  assign stop_det  = scl_s & r_scl_hist & ~r_sda_hist & sda_s;

endmodule

// File: rtl/i2c_mslave.sv
// I2C target serving an 8-bit-addressed local byte store through a
// persistent register pointer; sda is open-drain, scl is only sampled.
`timescale 1ns/1ps
module i2c_mslave
  import i2c_mslave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [6:0] devadr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic [7:0] adr_o,
  output logic       wr_o,
  output logic       rd_o,
  output logic       busy_o,
  inout  wire        sda,
  input  logic       scl
);

  logic w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop, w_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .scl_i     (scl),
    .sda_i     (sda),
    .scl_s     (w_scl_s),
    .sda_s     (w_sda_s),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  assign w_fall = w_scl_fall && !w_scl_s;

  state_t     r_state, w_state_next;
  logic [3:0] r_bitcnt, w_bitcnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic [7:0] r_tx, w_tx_next;
  logic [7:0] r_adr, w_adr_next;
  logic [7:0] r_dat, w_dat_next;
  logic       r_sda_out, w_sda_out_next;
  logic       r_busy, w_busy_next;
  logic       r_rw, w_rw_next;
  logic       r_mack, w_mack_next;
  logic       r_wr, w_wr_next;
  logic       r_rd, w_rd_next;
  logic       r_cap, w_cap_next;
  logic [7:0] w_shift_in;

  assign w_shift_in = {r_shift[6:0], w_sda_s};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      r_tx      <= 8'h00;
      r_adr     <= 8'h00;
      r_dat     <= 8'h00;
      r_sda_out <= NACK;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_mack    <= 1'b0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_cap     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bitcnt  <= w_bitcnt_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_adr     <= w_adr_next;
      r_dat     <= w_dat_next;
      r_sda_out <= w_sda_out_next;
      r_busy    <= w_busy_next;
      r_rw      <= w_rw_next;
      r_mack    <= w_mack_next;
      r_wr      <= w_wr_next;
      r_rd      <= w_rd_next;
      r_cap     <= w_cap_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bitcnt_next  = r_bitcnt;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_adr_next     = r_adr;
    w_dat_next     = r_dat;
    w_sda_out_next = r_sda_out;
    w_busy_next    = r_busy;
    w_rw_next      = r_rw;
    w_mack_next    = r_mack;
    w_wr_next      = 1'b0;
    w_rd_next      = 1'b0;
    w_cap_next     = r_rd;

    // The store presents the fetched byte one cycle after the rd_o pulse.
    if (r_cap) begin
      w_tx_next = dat_i;
    end

    if (w_stop) begin
      w_state_next   = S_IDLE;
      w_sda_out_next = NACK;
      w_busy_next    = 1'b0;
    end else if (w_start) begin
      w_state_next   = S_ADDR;
      w_bitcnt_next  = 4'd8;
      w_sda_out_next = NACK;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise && r_bitcnt != 4'd0) begin
            w_shift_next  = w_shift_in;
            w_bitcnt_next = r_bitcnt - 4'd1;
          end else if (w_fall && r_bitcnt == 4'd0) begin
            if (r_shift[7:1] == devadr_i && enable_i) begin
              w_sda_out_next = ACK;
              w_busy_next    = 1'b1;
              w_rw_next      = r_shift[0];
              w_state_next   = S_ACK_ADDR;
            end else begin
              w_busy_next  = 1'b0;
              w_state_next = S_IDLE;
            end
          end
        end
        S_ACK_ADDR: begin
          if (w_scl_rise && r_rw) begin
            w_rd_next = 1'b1;
          end else if (w_fall) begin
            if (r_rw) begin
              w_sda_out_next = r_tx[7];
              w_tx_next      = {r_tx[6:0], 1'b0};
              w_bitcnt_next  = 4'd7;
              w_state_next   = S_RDATA;
            end else begin
              w_sda_out_next = NACK;
              w_bitcnt_next  = 4'd8;
              w_state_next   = S_REG;
            end
          end
        end
        S_REG: begin
          if (w_scl_rise && r_bitcnt != 4'd0) begin
            w_shift_next  = w_shift_in;
            w_bitcnt_next = r_bitcnt - 4'd1;
          end else if (w_fall && r_bitcnt == 4'd0) begin
            w_adr_next     = r_shift;
            w_sda_out_next = ACK;
            w_state_next   = S_ACK_REG;
          end
        end
        S_ACK_REG: begin
          if (w_fall) begin
            w_sda_out_next = NACK;
            w_bitcnt_next  = 4'd8;
            w_state_next   = S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_scl_rise && r_bitcnt != 4'd0) begin
            w_shift_next  = w_shift_in;
            w_bitcnt_next = r_bitcnt - 4'd1;
          end else if (w_fall && r_bitcnt == 4'd0) begin
            w_dat_next     = r_shift;
            w_wr_next      = 1'b1;
            w_sda_out_next = ACK;
            w_state_next   = S_ACK_WDATA;
          end
        end
        S_ACK_WDATA: begin
          if (w_fall) begin
            w_adr_next     = r_adr + 8'd1;
            w_sda_out_next = NACK;
            w_bitcnt_next  = 4'd8;
            w_state_next   = S_WDATA;
          end
        end
        S_RDATA: begin
          if (w_fall) begin
            if (r_bitcnt != 4'd0) begin
              w_sda_out_next = r_tx[7];
              w_tx_next      = {r_tx[6:0], 1'b0};
              w_bitcnt_next  = r_bitcnt - 4'd1;
            end else begin
              w_sda_out_next = NACK;
              w_state_next   = S_CHK_ACK;
            end
          end
        end
        S_CHK_ACK: begin
          // Pointer advances on ACK and NACK alike; only ACK prefetches.
          if (w_scl_rise) begin
            w_adr_next  = r_adr + 8'd1;
            w_mack_next = (w_sda_s == ACK);
            w_rd_next   = (w_sda_s == ACK);
          end else if (w_fall) begin
            if (r_mack) begin
              w_sda_out_next = r_tx[7];
              w_tx_next      = {r_tx[6:0], 1'b0};
              w_bitcnt_next  = 4'd7;
              w_state_next   = S_RDATA;
            end else begin
              w_sda_out_next = NACK;
              w_state_next   = S_WAIT_STOP;
            end
          end
        end
        S_WAIT_STOP: begin
          w_sda_out_next = NACK;
        end
        S_IDLE: begin
          w_sda_out_next = NACK;
        end
        default: begin
          w_state_next   = S_IDLE;
          w_sda_out_next = NACK;
        end
      endcase
    end
  end

  assign sda    = (r_sda_out == NACK) ? 1'bz : 1'b0;
  assign dat_o  = r_dat;
  assign adr_o  = r_adr;
  assign wr_o   = r_wr;
  assign rd_o   = r_rd;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_i2c_mslave.sv
// Directed bench for i2c_mslave: a bit-banged bus master plus a registered
// byte-store model that returns 0x20 + address.
`timescale 1ns/1ps
module tb_i2c_mslave;

  localparam int Q = 5;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b1;
  logic [6:0] devadr_i = 7'h50;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o, adr_o;
  logic       wr_o, rd_o, busy_o;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #5 clock_i = ~clock_i;

  i2c_mslave #(.SYNC_STAGES(2)) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .devadr_i (devadr_i),
    .dat_i    (dat_i),
    .dat_o    (dat_o),
    .adr_o    (adr_o),
    .wr_o     (wr_o),
    .rd_o     (rd_o),
    .busy_o   (busy_o),
    .sda      (sda),
    .scl      (scl)
  );

  always @(posedge clock_i) begin
    if (rd_o) dat_i <= adr_o + 8'h20;
  end

  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] wr_adr_log [0:15];
  logic [7:0] wr_dat_log [0:15];

  always @(posedge clock_i) begin
    if (wr_o) begin
      if (wr_cnt < 16) begin
        wr_adr_log[wr_cnt] = adr_o;
        wr_dat_log[wr_cnt] = dat_o;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (rd_o) rd_cnt = rd_cnt + 1;
    if (wr_o && rd_o) both_cnt = both_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clock_i);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_sda_low = ~b;
    qwait();
    scl = 1'b1;
    qwait();
    r = sda;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    m_sda_low = 1'b1;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    qwait();
    scl = 1'b1;
    qwait();
    m_sda_low = 1'b0;
    qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       r;

    repeat (4) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (4) @(posedge clock_i);
    #1;
    chk("rst_dat_o", dat_o, 8'h00);
    chk("rst_adr_o", adr_o, 8'h00);
    chk("rst_wr_o", wr_o, 1'b0);
    chk("rst_rd_o", rd_o, 1'b0);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_sda", sda, 1'b1);

    // Byte write: reg 0x10 <= 0x5A
    i2c_start();
    write_byte(8'hA0, ack); chk("bw_ack_dev", ack, 1'b0);
    chk("bw_busy", busy_o, 1'b1);
    write_byte(8'h10, ack); chk("bw_ack_reg", ack, 1'b0);
    write_byte(8'h5A, ack); chk("bw_ack_dat", ack, 1'b0);
    chk("bw_wr_cnt", wr_cnt[7:0], 8'd1);
    chk("bw_wr_adr", wr_adr_log[0], 8'h10);
    chk("bw_wr_dat", wr_dat_log[0], 8'h5A);
    chk("bw_adr_after", adr_o, 8'h11);
    i2c_stop();
    chk("bw_busy_stop", busy_o, 1'b0);

    // Page write wrapping the pointer
    i2c_start();
    write_byte(8'hA0, ack); chk("pw_ack_dev", ack, 1'b0);
    write_byte(8'hFE, ack); chk("pw_ack_reg", ack, 1'b0);
    write_byte(8'h01, ack); chk("pw_ack_d0", ack, 1'b0);
    write_byte(8'h02, ack); chk("pw_ack_d1", ack, 1'b0);
    write_byte(8'h03, ack); chk("pw_ack_d2", ack, 1'b0);
    i2c_stop();
    chk("pw_wr_cnt", wr_cnt[7:0], 8'd4);
    chk("pw_adr0", wr_adr_log[1], 8'hFE);
    chk("pw_dat0", wr_dat_log[1], 8'h01);
    chk("pw_adr1", wr_adr_log[2], 8'hFF);
    chk("pw_dat1", wr_dat_log[2], 8'h02);
    chk("pw_adr2", wr_adr_log[3], 8'h00);
    chk("pw_dat2", wr_dat_log[3], 8'h03);
    chk("pw_adr_end", adr_o, 8'h01);

    // Random read from 0x20 with repeated START
    i2c_start();
    write_byte(8'hA0, ack); chk("rr_ack_dev", ack, 1'b0);
    write_byte(8'h20, ack); chk("rr_ack_reg", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, ack); chk("rr_ack_devr", ack, 1'b0);
    read_byte(1'b0, d); chk("rr_byte0", d, 8'h40);
    read_byte(1'b0, d); chk("rr_byte1", d, 8'h41);
    read_byte(1'b1, d); chk("rr_byte2", d, 8'h42);
    chk("rr_busy", busy_o, 1'b1);
    i2c_stop();
    chk("rr_rd_cnt", rd_cnt[7:0], 8'd3);
    chk("rr_adr_end", adr_o, 8'h23);
    chk("rr_busy_stop", busy_o, 1'b0);
    chk("rr_wr_cnt", wr_cnt[7:0], 8'd4);

    // Current-address read, NACK
    i2c_start();
    write_byte(8'hA1, ack); chk("cr_ack_dev", ack, 1'b0);
    read_byte(1'b1, d); chk("cr_byte", d, 8'h43);
    chk("cr_sda_rel", sda, 1'b1);
    chk("cr_adr", adr_o, 8'h24);
    i2c_stop();
    chk("cr_rd_cnt", rd_cnt[7:0], 8'd4);

    // Address mismatch and disabled target
    i2c_start();
    write_byte(8'hA2, ack); chk("mm_nack", ack, 1'b1);
    chk("mm_busy", busy_o, 1'b0);
    i2c_stop();
    enable_i = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack); chk("dis_nack", ack, 1'b1);
    chk("dis_busy", busy_o, 1'b0);
    i2c_stop();
    enable_i = 1'b1;
    chk("mm_wr_cnt", wr_cnt[7:0], 8'd4);
    chk("mm_rd_cnt", rd_cnt[7:0], 8'd4);

    // STOP after 4 data bits discards the partial byte
    i2c_start();
    write_byte(8'hA0, ack); chk("ab_ack_dev", ack, 1'b0);
    write_byte(8'h30, ack); chk("ab_ack_reg", ack, 1'b0);
    bit_xfer(1'b1, r);
    bit_xfer(1'b0, r);
    bit_xfer(1'b1, r);
    bit_xfer(1'b0, r);
    i2c_stop();
    chk("ab_wr_cnt", wr_cnt[7:0], 8'd4);
    chk("ab_adr", adr_o, 8'h30);
    chk("ab_dat_o", dat_o, 8'h03);
    chk("ab_busy", busy_o, 1'b0);

    // Reset while driving the MSB (0) of byte 0x50
    i2c_start();
    write_byte(8'hA1, ack); chk("rs_ack_dev", ack, 1'b0);
    chk("rs_sda_drv", sda, 1'b0);
    chk("rs_rd_cnt", rd_cnt[7:0], 8'd5);
    @(negedge clock_i);
    reset_i = 1'b1;
    #1;
    chk("rs_sda_rel", sda, 1'b1);
    chk("rs_adr", adr_o, 8'h00);
    chk("rs_dat", dat_o, 8'h00);
    chk("rs_busy", busy_o, 1'b0);
    chk("rs_wr", wr_o, 1'b0);
    chk("rs_rd", rd_o, 1'b0);
    @(negedge clock_i);
    reset_i = 1'b0;
    i2c_stop();

    chk("wr_rd_overlap", both_cnt[7:0], 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
